// File: rtl/dma_bus_arbiter.sv
// Purpose : OAM DMA engine sharing the system bus with the CPU; FF46 write copies DMA_LEN bytes to DMA_DST.
// Latency : 1 + 2*DMA_LEN cycles per transfer (START, then READ/WRITE pairs); CPU passthrough is combinational.
// Backpressure: CPU accesses never stall; without lockout a CPU bus access steals the cycle and holds the DMA.
//
// Ports:
//   clk, rst         - system clock; asynchronous active-low reset
//   cpu_a/dout/we/re - CPU address, write data, write and read strobes
//   cpu_din          - read data returned to the CPU
//   bus_a/dout/we/re - shared system bus master outputs
//   bus_din          - read data from the shared bus
//   dma_active       - high in START, READ and WRITE
//   cpu_blocked      - high when the current CPU access is refused
//
// Optional feature: define DMA_CPU_LOCKOUT_EN to lock the CPU off the bus
// while a transfer runs (otherwise the CPU has priority and steals cycles).
module dma_bus_arbiter #(
    parameter int unsigned DMA_LEN = 160,
    parameter logic [15:0] DMA_DST = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_din,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_din,
    output logic        dma_active,
    output logic        cpu_blocked
);

    localparam logic [15:0] REG_ADDR = 16'hFF46;
    localparam logic [15:0] HRAM_LO  = 16'hFF80;
    localparam logic [15:0] HRAM_HI  = 16'hFFFE;
    localparam logic [7:0]  LAST_IDX = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_READ  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  latch_q, latch_d;

    // ------------------------------------------------------------------
    // CPU access decode
    // ------------------------------------------------------------------
    logic       cpu_acc;
    logic       is_reg;
    logic       is_hram;
    logic       reg_wr;
    logic       cpu_other;  // CPU access that would need the shared bus
    logic       in_xfer;
    logic       steal;      // CPU takes this bus cycle, DMA holds
    logic       blocked;
    logic [7:0] eff_hi;

    assign cpu_acc   = cpu_re | cpu_we;
    assign is_reg    = (cpu_a == REG_ADDR);
    assign is_hram   = (cpu_a >= HRAM_LO) && (cpu_a <= HRAM_HI);
    assign reg_wr    = cpu_we && is_reg;
    assign cpu_other = cpu_acc && !is_reg && !is_hram;
    assign in_xfer   = (state_q == ST_READ) || (state_q == ST_WRITE);

`ifdef DMA_CPU_LOCKOUT_EN
    // CPU is refused for the whole transfer, START included; DMA timing
    // is unaffected.
    assign steal   = 1'b0;
    assign blocked = (in_xfer || (state_q == ST_START)) && cpu_other;
`else
    // CPU has priority: it wins any READ/WRITE cycle in which it needs the
    // bus, and the DMA simply repeats that state on the next cycle.
    assign steal   = in_xfer && cpu_other;
    assign blocked = 1'b0;
`endif

    // Sources in the echo region E000-FDFF are fetched from the WRAM they
    // mirror.
    assign eff_hi = (src_hi_q >= 8'hE0) ? (src_hi_q - 8'h20) : src_hi_q;

    assign dma_active = (state_q != ST_IDLE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            latch_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            latch_q  <= latch_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        latch_d  = latch_q;

        if (reg_wr) begin
            // Start or restart from any state; the byte in flight is dropped.
            src_hi_d = cpu_dout;
            state_d  = ST_START;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_START: begin
                    idx_d   = 8'h00;
                    state_d = ST_READ;
                end
                ST_READ: begin
                    if (!steal) begin
                        latch_d = bus_din;
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!steal) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_IDLE;
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            state_d = ST_READ;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus mux and CPU read data
    // ------------------------------------------------------------------
    always_comb begin
        bus_a       = 16'h0000;
        bus_dout    = 8'h00;
        bus_we      = 1'b0;
        bus_re      = 1'b0;
        cpu_din     = 8'hFF;
        cpu_blocked = blocked;

        if (is_reg) begin
            cpu_din = src_hi_q;
        end

        unique case (state_q)
            ST_IDLE: begin
                // The DMA register is internal and never appears on the bus.
                if (!is_reg) begin
                    bus_a    = cpu_a;
                    bus_dout = cpu_dout;
                    bus_we   = cpu_we;
                    bus_re   = cpu_re;
                    cpu_din  = bus_din;
                end
            end
            ST_START: begin
                bus_we = 1'b0;
                bus_re = 1'b0;
            end
            ST_READ, ST_WRITE: begin
                if (reg_wr) begin
                    // Restart cycle: keep the bus quiet so the abandoned
                    // byte is never written.
                    bus_we = 1'b0;
                    bus_re = 1'b0;
                end else if (steal) begin
                    bus_a    = cpu_a;
                    bus_dout = cpu_dout;
                    bus_we   = cpu_we;
                    bus_re   = cpu_re;
                    cpu_din  = bus_din;
                end else if (state_q == ST_READ) begin
                    bus_a  = {eff_hi, idx_q};
                    bus_re = 1'b1;
                end else begin
                    bus_a    = DMA_DST + {8'h00, idx_q};
                    bus_dout = latch_q;
                    bus_we   = 1'b1;
                end
            end
            default: begin
                bus_we = 1'b0;
                bus_re = 1'b0;
            end
        endcase

        // IDLE passes CPU strobes straight through, so hold them off
        // explicitly while reset is asserted.
        if (!rst) begin
            bus_we      = 1'b0;
            bus_re      = 1'b0;
            cpu_blocked = 1'b0;
        end
    end

endmodule

// File: doc/dma_bus_arbiter.md
DMA_BUS_ARBITER -- requirements
Module: dma_bus_arbiter

Interface
REQ-001 SHALL have parameter DMA_LEN, default 160, giving the bytes per transfer.
REQ-002 SHALL have parameter DMA_DST, default 16'hFE00, giving the OAM destination base.
REQ-003 SHALL have port clk, input, 1 bit: the 4.19MHz system clock, the only clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have ports cpu_a (input, 16 bits), cpu_dout (input, 8 bits), cpu_we (input, 1 bit) and cpu_re (input, 1 bit): the CPU address, write data, write strobe and read strobe.
REQ-006 SHALL have port cpu_din, output, 8 bits: read data returned to the CPU.
REQ-007 SHALL have ports bus_a (output, 16 bits), bus_dout (output, 8 bits), bus_we (output, 1 bit) and bus_re (output, 1 bit): the shared system bus.
REQ-008 SHALL have port bus_din, input, 8 bits: read data from the shared bus.
REQ-009 SHALL have port dma_active, output, 1 bit: high while a transfer is in progress.
REQ-010 SHALL have port cpu_blocked, output, 1 bit: high when the current CPU access is denied.

Function
REQ-011 SHALL hold an 8-bit register at FF46 (src_hi); a CPU write to FF46 loads it in any state and starts or restarts a transfer.
REQ-012 SHALL return src_hi on cpu_din for a CPU read of FF46 in any state; FF46 accesses SHALL never be driven onto the bus.
REQ-013 SHALL implement the states IDLE, START, READ and WRITE.
REQ-014 IDLE: SHALL pass the CPU through combinationally, i.e. bus_a=cpu_a, bus_we=cpu_we, bus_re=cpu_re, bus_dout=cpu_dout, cpu_din=bus_din.
REQ-015 START: SHALL last one cycle with the bus idle (bus_re=bus_we=0), clear idx to 0 and then go to READ.
REQ-016 READ: SHALL drive bus_a={eff_hi,idx} with bus_re=1 and latch bus_din at the clock edge, then go to WRITE.
REQ-017 WRITE: SHALL drive bus_a=DMA_DST+idx, bus_we=1 and bus_dout=the latched byte; if idx==DMA_LEN-1 it SHALL go to IDLE, otherwise increment idx and go to READ.
REQ-018 eff_hi SHALL be src_hi-8'h20 when src_hi>=8'hE0, and src_hi otherwise.
REQ-019 A transfer SHALL take 1+2*DMA_LEN cycles (321 at default) from the FF46 write edge to the return to IDLE.
REQ-020 dma_active SHALL be high in START, READ and WRITE.
REQ-021 A FF46 write in READ, WRITE or START SHALL abandon the current byte and enter START with the new src_hi; bytes already written are not undone.
REQ-022 idx SHALL be 8 bits and SHALL never exceed DMA_LEN-1.
REQ-023 CPU accesses to FF80-FFFE while dma_active SHALL set cpu_blocked=0, SHALL not be forwarded to the bus, and SHALL set cpu_din=8'hFF; the CPU's internal HRAM services them.

Reset
REQ-024 rst low SHALL asynchronously force IDLE, src_hi=8'h00, idx=0, latch=8'h00, dma_active=0 and cpu_blocked=0.
REQ-025 A reset asserted mid-transfer SHALL abort the transfer with no further bus write.
REQ-026 In reset, all bus strobes SHALL be 0.

Configuration
REQ-027 With macro DMA_CPU_LOCKOUT_EN defined, while dma_active any CPU access outside FF80-FFFE and FF46 SHALL assert cpu_blocked, drop writes, return 8'hFF on reads, and leave the DMA timing unchanged.
REQ-028 With DMA_CPU_LOCKOUT_EN undefined, the CPU SHALL have priority: on a cycle with cpu_re|cpu_we to an address outside FF80-FFFE and FF46 during READ or WRITE, the CPU access passes through per REQ-014, the DMA holds its state and idx, cpu_blocked=0, and the transfer lengthens by one cycle per stolen cycle.

Verification
REQ-029 Write 8'hC1 to FF46 with WRAM C100-C19F preloaded with i^8'h5A -> 160 writes FE00+i=i^8'h5A, alternating read/write cycles, dma_active high for exactly 321 cycles.
REQ-030 Write 8'hFE to FF46 -> read addresses DE00-DE9F (echo remap).
REQ-031 Restart: write 8'hC2 to FF46 at idx=50 -> one START cycle, then idx=0 and reads from C200; OAM FE00-FE31 retains bytes from C1xx until overwritten.
REQ-032 With lockout enabled, CPU reads 8000 and FF85 mid-transfer -> cpu_din=FF, cpu_blocked=1 for the 8000 read and 0 for the FF85 read; a CPU write to C000 is not seen on the bus.
REQ-033 With lockout disabled, 10 CPU reads of 0150 mid-transfer -> the bus shows the CPU address on those cycles, total transfer length 331 cycles, OAM contents still correct.
REQ-034 Drive rst low at idx=80 during WRITE -> bus_we=0 immediately, state IDLE, FF46 reads 8'h00.
